// File: rtl/AluCtrlSig_pkg.sv
// Shared MIPS opcode/funct encodings plus the scoreboard record and error codes.
package AluCtrlSig_pkg;

   // Primary opcodes (inst[31:26])
   localparam logic [5:0] ADD_op  = 6'h00;   // R-type group
   localparam logic [5:0] J_op    = 6'h02;
   localparam logic [5:0] BEQ_op  = 6'h04;
   localparam logic [5:0] BNE_op  = 6'h05;
   localparam logic [5:0] ADDI_op = 6'h08;
   localparam logic [5:0] LW_op   = 6'h23;
   localparam logic [5:0] SW_op   = 6'h2B;

   // R-type function codes (inst[5:0])
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26;
   localparam logic [5:0] F_NOR = 6'h27;
   localparam logic [5:0] F_SLT = 6'h2A;

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      DATA      = 3'd1,
      BRANCH    = 3'd2,
      JUMP      = 3'd3,
      ILLEGAL   = 3'd4,
      UNDERFLOW = 3'd5
   } err_code_e;

   // Decoded view of one issued instruction, as held in the in-flight queue
   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [5:0]  funct;
      logic [15:0] imm16;
      logic [25:0] jtarget26;
   } chk_rec_t;

   function automatic chk_rec_t decode_inst(input logic [31:0] inst);
      chk_rec_t r;
      r.opcode    = inst[31:26];
      r.rs        = inst[25:21];
      r.rt        = inst[20:16];
      r.funct     = inst[5:0];
      r.imm16     = inst[15:0];
      r.jtarget26 = inst[25:0];
      return r;
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/mips_scoreboard_chk_fifo.sv
// Synchronous FIFO of arbitrary element type; head is visible combinationally.
module chk_fifo #(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  T                         din,
   output T                         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    level_reg;
   logic           do_push;
   logic           do_pop;

   assign empty   = (level_reg == '0);
   assign full    = (level_reg == (AW+1)'(DEPTH));
   // A pop at full frees a slot in the same edge, so a push is accepted then
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr_reg];
   assign level   = level_reg;

   // Storage write; contents need no reset because level gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + (AW+1)'(1);
            2'b01:   level_reg <= level_reg - (AW+1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/mips_scoreboard.sv
// Retire-time checker for the MIPS CPU: queues issued instructions, recomputes
// expected results on retire and keeps pass/fail statistics.
module mips_scoreboard
   import AluCtrlSig_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DM_AW = 5,
   parameter int CW    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   iss_valid,
   input  logic [31:0]            iss_inst,
   input  logic                   res_valid,
   input  logic [31:0]            rs_value,
   input  logic [31:0]            rt_value,
   input  logic [31:0]            rd_value,
   input  logic [31:0]            lw_data,
   input  logic [31:0]            branch_addr,
   input  logic [31:0]            jump_addr,
   input  logic                   res_taken,
   output logic                   op_done,
   output logic                   op_err,
   output logic [2:0]             err_code,
   output logic                   err_sticky,
   output logic [CW-1:0]          pass_cnt,
   output logic [CW-1:0]          fail_cnt,
   output logic [$clog2(DEPTH):0] q_level,
   output logic                   overflow,
   output logic                   underflow
);
   localparam int DM_WORDS = 2 ** DM_AW;

   chk_rec_t          iss_rec;
   chk_rec_t          head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              retire_ok;
   logic              overflow_ev;
   logic              underflow_ev;
   logic              sw_we;
   logic [31:0]       ea;
   logic [DM_AW-1:0]  mem_idx;
   logic [31:0]       alu_res;
   logic              pass;
   err_code_e         fail_code;
   logic              unused_bits;

   logic [31:0]       dm_reg [DM_WORDS];
   logic              op_done_reg, op_err_reg, err_sticky_reg;
   logic              overflow_reg, underflow_reg;
   err_code_e         err_code_reg;
   logic [CW-1:0]     pass_cnt_reg, fail_cnt_reg;

   assign iss_rec = decode_inst(iss_inst);

   chk_fifo #(.T(chk_rec_t), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (iss_valid),
      .pop   (res_valid),
      .din   (iss_rec),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (q_level)
   );

   assign retire_ok    = res_valid && !fifo_empty;
   assign underflow_ev = res_valid && fifo_empty;
   // At full the queue is non-empty, so any retire makes room for the issue
   assign overflow_ev  = iss_valid && fifo_full && !res_valid;
   assign sw_we        = retire_ok && (head.opcode == SW_op);
   assign unused_bits  = ^{head.rs, head.rt, ea[31:DM_AW+2], ea[1:0]};

   // Recompute the expected outcome of the head record against the retire bus
   always_comb begin
      ea        = rs_value + sext16(head.imm16);
      mem_idx   = ea[DM_AW+1:2];
      alu_res   = '0;
      pass      = 1'b0;
      fail_code = NONE;
      case (head.opcode)
         ADD_op: begin
            fail_code = DATA;
            case (head.funct)
               F_ADD:   alu_res = rs_value + rt_value;
               F_SUB:   alu_res = rs_value - rt_value;
               F_AND:   alu_res = rs_value & rt_value;
               F_OR:    alu_res = rs_value | rt_value;
               F_XOR:   alu_res = rs_value ^ rt_value;
               F_NOR:   alu_res = ~(rs_value | rt_value);
               F_SLT:   alu_res = {31'd0, $signed(rs_value) < $signed(rt_value)};
               default: fail_code = ILLEGAL;
            endcase
            if (fail_code == DATA) pass = (rd_value == alu_res);
         end
         ADDI_op: begin
            fail_code = DATA;
            pass      = (rd_value == ea);
         end
         LW_op: begin
            fail_code = DATA;
            pass      = (lw_data == dm_reg[mem_idx]) && (rd_value == lw_data);
         end
         SW_op: begin
            pass = 1'b1;
         end
         BEQ_op, BNE_op: begin
            fail_code = BRANCH;
            pass      = (res_taken == ((rs_value == rt_value) ^ (head.opcode == BNE_op)))
                        && (branch_addr == {14'd0, head.imm16, 2'b00});
         end
         J_op: begin
            fail_code = JUMP;
            pass      = (jump_addr == {4'b0000, head.jtarget26, 2'b00});
         end
         default: fail_code = ILLEGAL;
      endcase
   end

   // Reference data memory, written back by retired stores
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DM_WORDS; i++) dm_reg[i] <= '0;
      end else if (sw_we) begin
         dm_reg[mem_idx] <= rt_value;
      end
   end

   // Result pulses, error cause, sticky faults and saturating counters
   always_ff @(posedge clk) begin
      if (reset) begin
         op_done_reg    <= 1'b0;
         op_err_reg     <= 1'b0;
         err_code_reg   <= NONE;
         err_sticky_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
         pass_cnt_reg   <= '0;
         fail_cnt_reg   <= '0;
      end else begin
         op_done_reg <= retire_ok && pass;
         op_err_reg  <= underflow_ev || (retire_ok && !pass);
         if (underflow_ev)
            err_code_reg <= UNDERFLOW;
         else if (retire_ok && !pass)
            err_code_reg <= fail_code;
         if (underflow_ev || overflow_ev || (retire_ok && !pass))
            err_sticky_reg <= 1'b1;
         if (overflow_ev)  overflow_reg  <= 1'b1;
         if (underflow_ev) underflow_reg <= 1'b1;
         if (retire_ok && pass && (pass_cnt_reg != '1))
            pass_cnt_reg <= pass_cnt_reg + CW'(1);
         if ((underflow_ev || (retire_ok && !pass)) && (fail_cnt_reg != '1))
            fail_cnt_reg <= fail_cnt_reg + CW'(1);
      end
   end

   assign op_done    = op_done_reg;
   assign op_err     = op_err_reg;
   assign err_code   = err_code_reg;
   assign err_sticky = err_sticky_reg;
   assign pass_cnt   = pass_cnt_reg;
   assign fail_cnt   = fail_cnt_reg;
   assign overflow   = overflow_reg;
   assign underflow  = underflow_reg;

endmodule
